row_renderer: RTL and testbench
===============================

# row_renderer

Parametrised per-scanline sprite renderer, successor to the fixed 48×48 row drawer. On each `swap` it advances to the next display row. It walks the entity list, fetches the matching sprite line from an external sprite ROM, and writes non-transparent pixels into the row line buffer. New behaviour over the previous generation: generic geometry, horizontal mirroring, right-edge clipping, external ROM port, and `busy`/`done` status. It sits between the entity RAM, the sprite ROM and the double-buffered row RAM that feeds the VGA scanout.

## Interface
Parameters:
- `SPR_DIM` = 48: sprite width and height in pixels.
- `N_TYPES` = 8: number of sprite types in the ROM; `TYPE_W` = clog2(`N_TYPES`).
- `COORD_W` = 10: width of each row/column coordinate.
- `ROW_W` = 640: visible pixels per row; column clip limit.
- `MAX_ROW` = 480: rows per frame.
- `PIX_W` = 24: pixel width (RGB888).
- `ENT_AW` = 8: entity RAM address width.
- `TRANSPARENT` = 0: pixel value that is never written.

Ports, as name, direction, width, meaning:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `swap` in 1: single-cycle pulse that starts rendering the next row.
- `entities_number` in `ENT_AW`: entity count, sampled on `swap`.
- `ent_addr` out `ENT_AW`: entity RAM read address.
- `ent_data` in 1+`TYPE_W`+2·`COORD_W`: entity word {mirror, type, start_row, start_col}, MSB first.
- `rom_addr` out clog2(`N_TYPES`·`SPR_DIM`²): sprite ROM read address.
- `rom_data` in `PIX_W`: sprite ROM pixel.
- `row_addr` out `COORD_W`: line-buffer write column.
- `row_data` out `PIX_W`: line-buffer write pixel.
- `row_wren` out 1: line-buffer write strobe.
- `busy` out 1: high while a row is being rendered.
- `done` out 1: one-cycle pulse when the row is complete.

## Operation
- Entity RAM and sprite ROM are synchronous, with 1-cycle read latency.
- Row counter `row_q` is reset to `MAX_ROW`-1, so the first `swap` renders row 0.
  - On each `swap`: `row_q` ← (`row_q` = `MAX_ROW`-1) ? 0 : `row_q`+1.
- FSM states: IDLE, ENT_RD, CHECK, DRAW, DRAIN, DONE.
- IDLE → ENT_RD on `swap`: `ent_addr`←0, `busy`←1, latch `entities_number`.
  - If the latched count is 0, go straight to DONE.
- ENT_RD: one cycle waiting for `ent_data`.
- CHECK: the entity is visible iff `start_row` ≤ `row_q` < `start_row`+`SPR_DIM`.
  - Compare at `COORD_W`+1 bits, so there is no wrap near the top coordinate.
  - Not visible: `ent_addr`+1 and go to ENT_RD, or go to DONE if this was the last entity.
  - Visible: capture the entity, clear the pixel counter `i`, go to DRAW.
- DRAW runs for `SPR_DIM` cycles, issuing one ROM address per cycle:
  - `rom_addr` = type·`SPR_DIM`² + (`row_q`−`start_row`)·`SPR_DIM` + (mirror ? `SPR_DIM`-1-`i` : `i`).
- Write pipeline (2 stages), for pixel `i`:
  - `row_addr` = `start_col`+`i`.
  - `row_data` = `rom_data`.
  - `row_wren` = (`rom_data` ≠ `TRANSPARENT`) && (`start_col`+`i` < `ROW_W`), with the sum computed at `COORD_W`+1 bits.
- DRAIN: 2 cycles to flush the pipeline, then go to ENT_RD (next entity) or DONE.
- DONE: `done`=1 for one cycle, `busy`←0, go to IDLE.
- Overlap priority: entities are drawn in index order, so a higher index overwrites lower ones.
- `swap` in any non-IDLE state aborts the current row:
  - `row_wren` is forced to 0 on the same edge and the pipeline is flushed.
  - The row counter advances and rendering restarts at entity 0.
  - No `done` pulse is issued for the aborted row.
- Reset values: all outputs 0 (`ent_addr`, `rom_addr`, `row_addr`, `row_data`, `row_wren`, `busy`, `done`); FSM in IDLE.

## Timing
- `swap` sampled at edge E: `ent_addr`=0 is valid in cycle E+1, and CHECK falls in cycle E+2.
- Skipped entity: 2 cycles (ENT_RD + CHECK).
- Visible entity: `SPR_DIM`+4 cycles (ENT_RD, CHECK, `SPR_DIM` DRAW cycles, 2 DRAIN cycles). This is 52 cycles at defaults.
- Pixel `i` address is presented in cycle C+1+`i` (C = the CHECK cycle); its write appears in cycle C+3+`i`.
- Worst-case budget: 255 visible entities at defaults = 13,260 cycles. Software must size the entity list to fit the row period.

## Structure
- Shared package `row_render_pkg` holds:
  - the FSM state enum;
  - entity-word field offsets and widths;
  - the ROM address-width function.
- Sub-module `sprite_line_fetch` contains the pixel counter, mirrored address generation and the 2-stage write/clip/transparency pipeline.
  - It takes a start strobe and reports when it is finished.
- The top level holds the FSM, row counter and entity walk.

## Test plan
- Reset, then `swap` with 0 entities → `busy` high for 2 cycles, `done` pulses, `row_wren` never asserts, row counter = 0.
- One entity {mirror=0, type=1, row=0, col=100}, ROM pixel = address+1 → 48 writes at columns 100..147, data 2305..2352, first write in cycle E+5.
- Same entity with mirror=1 → column 100 receives data 2352 and column 147 receives data 2305.
- Entity at col=620 → only columns 620..639 are written (20 strobes), none at ≥640.
- ROM rows containing `TRANSPARENT` pixels → no `row_wren` for those pixels; two overlapping entities at the same column → entity 1's pixel is the last write.
- `swap` mid-DRAW → `row_wren` is 0 the next cycle, no `done` pulse, rendering restarts at `ent_addr`=0 on the next row.
- Row wrap: after 480 swaps the row counter returns to 0, and an entity at start_row=0 is drawn again.

Source files
------------

// File: rtl/row_render_pkg.sv
// row_render_pkg: shared FSM state type, entity-word field layout and ROM address width for row_renderer
package row_render_pkg;
  typedef enum logic [2:0] {IDLE, ENT_RD, CHECK, DRAW, DRAIN, DONE} state_t;
  function automatic int ent_w(input int tw, input int cw);
    return 1 + tw + 2 * cw;
  endfunction
  function automatic int row_lsb(input int cw);
    return cw;
  endfunction
  function automatic int type_lsb(input int cw);
    return 2 * cw;
  endfunction
  function automatic int mir_bit(input int tw, input int cw);
    return 2 * cw + tw;
  endfunction
  function automatic int rom_aw(input int n, input int d);
    return $clog2(n * d * d);
  endfunction
endpackage

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: one sprite line, mirrored ROM addressing plus 2-stage clip/transparency write pipeline (start/abort in; rom_addr, row_* out; last = final address issued, fin = pipeline empty)
module sprite_line_fetch
  import row_render_pkg::*;
#(
  parameter int SPR_DIM = 48,
  parameter int TYPE_W = 3,
  parameter int COORD_W = 10,
  parameter int ROW_W = 640,
  parameter int PIX_W = 24,
  parameter logic [PIX_W-1:0] TRANSPARENT = '0,
  parameter int AW = rom_aw(8, 48),
  parameter int IW = $clog2(SPR_DIM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mirror,
  input  logic [TYPE_W-1:0]  typ,
  input  logic [IW-1:0]      rel,
  input  logic [COORD_W-1:0] col,
  input  logic [PIX_W-1:0]   rom_data,
  output logic [AW-1:0]      rom_addr,
  output logic [COORD_W-1:0] row_addr,
  output logic [PIX_W-1:0]   row_data,
  output logic               row_wren,
  output logic               last,
  output logic               fin
);
  localparam logic [AW-1:0] DD = AW'(SPR_DIM * SPR_DIM);
  logic               iss, p1_v, mir_q, m;
  logic [IW-1:0]      i, ni;
  logic [AW-1:0]      base_q, b;
  logic [COORD_W-1:0] col_q;
  logic [COORD_W:0]   p1_col;
  assign ni = start ? '0 : i + 1'b1;
  assign b = start ? AW'(typ) * DD + AW'(rel) * AW'(SPR_DIM) : base_q;
  assign m = start ? mirror : mir_q;
  assign last = iss && i == IW'(SPR_DIM - 1);
  assign fin = !iss && !p1_v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss <= 1'b0;
      i <= '0;
      base_q <= '0;
      mir_q <= 1'b0;
      col_q <= '0;
      p1_v <= 1'b0;
      p1_col <= '0;
      rom_addr <= '0;
      row_addr <= '0;
      row_data <= '0;
      row_wren <= 1'b0;
    end else if (abort) begin
      iss <= 1'b0;
      p1_v <= 1'b0;
      row_wren <= 1'b0;
    end else begin
      if (start || (iss && !last)) begin
        iss <= 1'b1;
        i <= ni;
        base_q <= b;
        mir_q <= m;
        rom_addr <= b + (m ? AW'(SPR_DIM - 1) - AW'(ni) : AW'(ni));
      end else iss <= 1'b0;
      if (start) col_q <= col;
      p1_v <= iss;
      p1_col <= {1'b0, col_q} + (COORD_W + 1)'(i);
      row_addr <= p1_col[COORD_W-1:0];
      row_data <= rom_data;
      row_wren <= p1_v && rom_data != TRANSPARENT && p1_col < (COORD_W + 1)'(ROW_W);
    end
  end
endmodule

// File: rtl/row_renderer.sv
// row_renderer: per-scanline sprite renderer (swap/entities_number in; ent_addr/ent_data entity RAM, rom_addr/rom_data sprite ROM, row_* line-buffer writes, busy/done status)
module row_renderer
  import row_render_pkg::*;
#(
  parameter int SPR_DIM = 48,
  parameter int N_TYPES = 8,
  parameter int TYPE_W = $clog2(N_TYPES),
  parameter int COORD_W = 10,
  parameter int ROW_W = 640,
  parameter int MAX_ROW = 480,
  parameter int PIX_W = 24,
  parameter int ENT_AW = 8,
  parameter logic [PIX_W-1:0] TRANSPARENT = '0,
  parameter int ROM_AW = rom_aw(N_TYPES, SPR_DIM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                swap,
  input  logic [ENT_AW-1:0]                   entities_number,
  output logic [ENT_AW-1:0]                   ent_addr,
  input  logic [ent_w(TYPE_W, COORD_W)-1:0]   ent_data,
  output logic [ROM_AW-1:0]                   rom_addr,
  input  logic [PIX_W-1:0]                    rom_data,
  output logic [COORD_W-1:0]                  row_addr,
  output logic [PIX_W-1:0]                    row_data,
  output logic                                row_wren,
  output logic                                busy,
  output logic                                done
);
  localparam int IW = $clog2(SPR_DIM);
  state_t             state, nxt;
  logic [COORD_W-1:0] row_q, srow, scol;
  logic [TYPE_W-1:0]  typ;
  logic [IW-1:0]      rel;
  logic [ENT_AW-1:0]  cnt;
  logic               mir, vis, last_ent, last, fin, start;
  assign scol = ent_data[0 +: COORD_W];
  assign srow = ent_data[row_lsb(COORD_W) +: COORD_W];
  assign typ = ent_data[type_lsb(COORD_W) +: TYPE_W];
  assign mir = ent_data[mir_bit(TYPE_W, COORD_W)];
  assign rel = IW'(row_q - srow);
  assign vis = {1'b0, srow} <= {1'b0, row_q} && {1'b0, row_q} < {1'b0, srow} + (COORD_W + 1)'(SPR_DIM);
  assign last_ent = ent_addr == cnt - 1'b1;
  assign start = state == CHECK && vis && !swap;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      ENT_RD: nxt = cnt == '0 ? DONE : CHECK;
      CHECK: nxt = vis ? DRAW : last_ent ? DONE : ENT_RD;
      DRAW: nxt = last ? DRAIN : DRAW;
      DRAIN: nxt = !fin ? DRAIN : last_ent ? DONE : ENT_RD;
      default: nxt = IDLE;
    endcase
    if (swap) nxt = ENT_RD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row_q <= COORD_W'(MAX_ROW - 1);
      ent_addr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (swap) begin
        row_q <= row_q == COORD_W'(MAX_ROW - 1) ? '0 : row_q + 1'b1;
        ent_addr <= '0;
        cnt <= entities_number;
      end else if (nxt == ENT_RD) ent_addr <= ent_addr + 1'b1;
    end
  end
  sprite_line_fetch #(
    .SPR_DIM(SPR_DIM), .TYPE_W(TYPE_W), .COORD_W(COORD_W), .ROW_W(ROW_W),
    .PIX_W(PIX_W), .TRANSPARENT(TRANSPARENT), .AW(ROM_AW), .IW(IW)
  ) u_fetch (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(swap), .mirror(mir), .typ(typ),
    .rel(rel), .col(scol), .rom_data(rom_data), .rom_addr(rom_addr), .row_addr(row_addr),
    .row_data(row_data), .row_wren(row_wren), .last(last), .fin(fin)
  );
endmodule

// File: tb/tb_row_renderer.sv
// tb_row_renderer: self-checking bench for row_renderer against a line-buffer reference model
module tb_row_renderer;
  logic        clk = 0, rst_n, swap;
  logic [7:0]  entities_number, ent_addr;
  logic [23:0] ent_data, rom_data, row_data;
  logic [14:0] rom_addr;
  logic [9:0]  row_addr;
  logic        row_wren, busy, done;
  logic [23:0] ent_mem [256];
  logic [23:0] rom [18432];
  int lb [640];
  int exp_lb [640];
  int checks = 0, failures = 0;
  int cyc = 0, s_cyc, tb_row = 479;
  int wr_cnt, oob, done_cnt, busy_cnt, first_wr, done_cyc, first_addr, first_data, last_addr, last_data;
  int exp_wr, exp_busy;

  row_renderer dut (
    .clk(clk), .rst_n(rst_n), .swap(swap), .entities_number(entities_number),
    .ent_addr(ent_addr), .ent_data(ent_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .row_addr(row_addr), .row_data(row_data), .row_wren(row_wren), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    ent_data <= ent_mem[ent_addr];
    rom_data <= rom_addr < 15'd18432 ? rom[rom_addr] : 24'd0;
  end

  always @(negedge clk) begin
    if (row_wren) begin
      wr_cnt++;
      if (row_addr >= 640) oob++;
      else lb[row_addr] = int'(row_data);
      if (first_wr < 0) begin
        first_wr = cyc;
        first_addr = int'(row_addr);
        first_data = int'(row_data);
      end
      last_addr = int'(row_addr);
      last_data = int'(row_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input bit m, input int t, input int sr, input int sc);
    return {m, 3'(t), 10'(sr), 10'(sc)};
  endfunction

  function automatic int next_row();
    return tb_row == 479 ? 0 : tb_row + 1;
  endfunction

  task automatic fill_rom(input int mode);
    for (int a = 0; a < 18432; a++)
      rom[a] = mode == 0 ? 24'(a + 1) : ($urandom_range(0, 3) == 0 ? 24'd0 : 24'($urandom));
  endtask

  // Reference: paint every visible entity in index order into a plain array.
  task automatic model(input int n);
    int tot = 1;
    exp_wr = 0;
    for (int c = 0; c < 640; c++) exp_lb[c] = 0;
    for (int e = 0; e < n; e++) begin
      logic [23:0] w = ent_mem[e];
      int m = int'(w[23]), t = int'(w[22:20]), sr = int'(w[19:10]), sc = int'(w[9:0]);
      if (tb_row >= sr && tb_row < sr + 48) begin
        tot += 52;
        for (int i = 0; i < 48; i++) begin
          int c = sc + i;
          int p = int'(rom[t * 2304 + (tb_row - sr) * 48 + (m != 0 ? 47 - i : i)]);
          if (c < 640 && p != 0) begin
            exp_lb[c] = p;
            exp_wr++;
          end
        end
      end else tot += 2;
    end
    exp_busy = n == 0 ? 2 : tot;
  endtask

  task automatic start_row(input int n);
    swap = 1;
    entities_number = 8'(n);
    s_cyc = cyc;
    tb_row = next_row();
    model(n);
    @(posedge clk);
    wr_cnt = 0; oob = 0; done_cnt = 0; busy_cnt = 0; first_wr = -1; done_cyc = -1;
    for (int c = 0; c < 640; c++) lb[c] = 0;
    @(negedge clk);
    swap = 0;
  endtask

  task automatic finish_row(input string nm);
    int mm = 0;
    for (int k = 0; k < 20000 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 640; c++) if (lb[c] != exp_lb[c]) mm++;
    chk({nm, " done pulses"}, done_cnt, 1);
    chk({nm, " busy cycles"}, busy_cnt, exp_busy);
    chk({nm, " done cycle"}, done_cyc, s_cyc + exp_busy);
    chk({nm, " writes"}, wr_cnt, exp_wr);
    chk({nm, " out of range writes"}, oob, 0);
    chk({nm, " line mismatches"}, mm, 0);
  endtask

  typedef struct {
    string nm;
    bit mir;
    int typ, roff;
    bit abs_row;
    int col, exp_wr, f_col, f_dat, l_col, l_dat;
  } vec_t;

  initial begin
    vec_t v[10];
    v[0] = '{"plain", 0, 1, 0, 0, 100, 48, 100, 2305, 147, 2352};
    v[1] = '{"mirror", 1, 1, 0, 0, 100, 48, 100, 2352, 147, 2305};
    v[2] = '{"clip620", 0, 0, 5, 0, 620, 20, 620, 241, 639, 260};
    v[3] = '{"bottom line", 0, 7, 47, 0, 0, 48, 0, 18385, 47, 18432};
    v[4] = '{"mirror clip", 1, 2, 10, 0, 600, 40, 600, 5136, 639, 5097};
    v[5] = '{"col639", 0, 3, 0, 0, 639, 1, 639, 6913, 639, 6913};
    v[6] = '{"above", 0, 1, -1, 0, 100, 0, 0, 0, 0, 0};
    v[7] = '{"below", 0, 1, 48, 0, 100, 0, 0, 0, 0, 0};
    v[8] = '{"near top coord", 0, 1, 1000, 1, 100, 0, 0, 0, 0, 0};
    v[9] = '{"col640", 0, 1, 0, 0, 640, 0, 0, 0, 0, 0};
    rst_n = 0; swap = 0; entities_number = 0;
    fill_rom(0);
    for (int e = 0; e < 256; e++) ent_mem[e] = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {ent_addr, rom_addr, row_addr, row_data, row_wren, busy, done}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle outputs", {ent_addr, row_wren, busy, done}, 0);
    start_row(0);
    finish_row("empty");
    while (tb_row < 60) begin
      start_row(0);
      finish_row("advance");
    end
    for (int k = 0; k < 10; k++) begin
      ent_mem[0] = mk(v[k].mir, v[k].typ, v[k].abs_row ? v[k].roff : next_row() - v[k].roff, v[k].col);
      start_row(1);
      finish_row(v[k].nm);
      chk({v[k].nm, " table writes"}, wr_cnt, v[k].exp_wr);
      if (v[k].exp_wr > 0) begin
        chk({v[k].nm, " first col"}, first_addr, v[k].f_col);
        chk({v[k].nm, " first data"}, first_data, v[k].f_dat);
        chk({v[k].nm, " last col"}, last_addr, v[k].l_col);
        chk({v[k].nm, " last data"}, last_data, v[k].l_dat);
        chk({v[k].nm, " first write cycle"}, first_wr, s_cyc + 5);
      end
    end
    rom[2304 + 3] = 0;
    rom[2304 + 5] = 0;
    ent_mem[0] = mk(0, 0, next_row(), 200);
    ent_mem[1] = mk(0, 1, next_row(), 200);
    start_row(2);
    finish_row("overlap");
    chk("overlap col200", lb[200], 2305);
    chk("transparent col203", lb[203], 4);
    chk("transparent col205", lb[205], 6);
    chk("overlap writes", wr_cnt, 94);
    fill_rom(0);
    ent_mem[0] = mk(0, 1, next_row(), 100);
    start_row(1);
    repeat (9) @(negedge clk);
    chk("pre-abort wren", row_wren, 1);
    start_row(1);
    chk("abort wren", row_wren, 0);
    chk("abort ent_addr", ent_addr, 0);
    chk("abort busy", busy, 1);
    finish_row("abort restart");
    chk("abort restart first write", first_wr, s_cyc + 5);
    fill_rom(1);
    for (int k = 0; k < 25; k++) begin
      int n = $urandom_range(0, 5);
      for (int e = 0; e < n; e++)
        ent_mem[e] = mk($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                        $urandom_range(0, 9) < 7 ? next_row() - int'($urandom_range(0, 50)) : int'($urandom_range(0, 1023)),
                        $urandom_range(0, 700));
      start_row(n);
      finish_row("random");
    end
    fill_rom(0);
    ent_mem[0] = mk(0, 0, 0, 0);
    for (int k = 0; k < 481; k++) begin
      start_row(1);
      finish_row("wrap");
      if (tb_row == 0) begin
        chk("row0 redraw writes", wr_cnt, 48);
        chk("row0 redraw first data", first_data, 1);
      end
      if (tb_row == 479) chk("row479 writes", wr_cnt, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
